// File: rtl/bram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// bram_portb_arbiter
//   Shares BRAM port B between the layer engine (req 0) and the result
//   writer (req 1). Round-robin grant with optional burst lock and a beat limit.
//   Read data is steered back to the issuing requester.
//   Optional statistics counters are enabled by defining PORTB_ARB_STATS_EN.
//   Revision: 1.0
// ============================================================================
module bram_portb_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              lock_0,
  input  logic              lock_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rd_valid_0,
  output logic              rd_valid_1,
  output logic [DATA_W-1:0] rd_data_0,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              BRAM_PORTB_en,
  output logic [3:0]        BRAM_PORTB_we,
  output logic [ADDR_W-1:0] BRAM_PORTB_addr,
  output logic [DATA_W-1:0] BRAM_PORTB_din,
  input  logic [DATA_W-1:0] BRAM_PORTB_dout,
  output logic              BRAM_PORTB_rst
`ifdef PORTB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_beats_0,
  output logic [31:0]       stat_beats_1,
  output logic [31:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t     state;
  state_t     state_nxt;
  logic       last_served;
  logic       last_served_nxt;
  logic [7:0] beat_cnt;
  logic [7:0] beat_cnt_nxt;
  logic       beat_0;
  logic       beat_1;
  logic       issue_rd;

  logic [RD_LAT:0] pipe_vld;
  logic [RD_LAT:0] pipe_tag;

  assign BRAM_PORTB_rst = s_axi_areset;

  // Grant decode; depends only on requests and arbiter state, never on dout.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    case (state)
      IDLE: begin
        if (req_0 && req_1) begin
          gnt_0 = last_served;
          gnt_1 = !last_served;
        end else begin
          gnt_0 = req_0;
          gnt_1 = req_1;
        end
      end
      OWN0: begin
        if (req_0) begin
          if (beat_cnt >= BURST_LIMIT && req_1) gnt_1 = 1'b1;
          else                                  gnt_0 = 1'b1;
        end else begin
          gnt_1 = req_1;
        end
      end
      OWN1: begin
        if (req_1) begin
          if (beat_cnt >= BURST_LIMIT && req_0) gnt_0 = 1'b1;
          else                                  gnt_1 = 1'b1;
        end else begin
          gnt_0 = req_0;
        end
      end
      default: begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
      end
    endcase
  end

  assign beat_0   = req_0 && gnt_0;
  assign beat_1   = req_1 && gnt_1;
  assign issue_rd = (beat_0 && !we_0) || (beat_1 && !we_1);

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    beat_cnt_nxt    = beat_cnt;
    if (beat_0) begin
      last_served_nxt = 1'b0;
      if (lock_0) begin
        state_nxt    = OWN0;
        // A beat at the limit with no competitor restarts the burst count.
        beat_cnt_nxt = (state == OWN0 && beat_cnt < BURST_LIMIT) ? beat_cnt + 8'd1 : 8'd1;
      end else begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 8'd0;
      end
    end else if (beat_1) begin
      last_served_nxt = 1'b1;
      if (lock_1) begin
        state_nxt    = OWN1;
        beat_cnt_nxt = (state == OWN1 && beat_cnt < BURST_LIMIT) ? beat_cnt + 8'd1 : 8'd1;
      end else begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 8'd0;
      end
    end else if (state != IDLE) begin
      state_nxt    = IDLE;
      beat_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      beat_cnt    <= 8'd0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      beat_cnt    <= beat_cnt_nxt;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      BRAM_PORTB_en   <= 1'b0;
      BRAM_PORTB_we   <= 4'h0;
      BRAM_PORTB_addr <= '0;
      BRAM_PORTB_din  <= '0;
    end else begin
      BRAM_PORTB_en <= beat_0 || beat_1;
      if (beat_0) begin
        BRAM_PORTB_we   <= we_0 ? 4'hF : 4'h0;
        BRAM_PORTB_addr <= addr_0;
        BRAM_PORTB_din  <= wdata_0;
      end else if (beat_1) begin
        BRAM_PORTB_we   <= we_1 ? 4'hF : 4'h0;
        BRAM_PORTB_addr <= addr_1;
        BRAM_PORTB_din  <= wdata_1;
      end else begin
        BRAM_PORTB_we   <= 4'h0;
      end
    end
  end

  // Stage 0 loads with the BRAM command; the last stage lines up with valid dout.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      pipe_vld   <= '0;
      pipe_tag   <= '0;
      rd_valid_0 <= 1'b0;
      rd_valid_1 <= 1'b0;
      rd_data_0  <= '0;
      rd_data_1  <= '0;
    end else begin
      pipe_vld   <= {pipe_vld[RD_LAT-1:0], issue_rd};
      pipe_tag   <= {pipe_tag[RD_LAT-1:0], beat_1};
      rd_valid_0 <= pipe_vld[RD_LAT] && !pipe_tag[RD_LAT];
      rd_valid_1 <= pipe_vld[RD_LAT] &&  pipe_tag[RD_LAT];
      if (pipe_vld[RD_LAT] && !pipe_tag[RD_LAT]) rd_data_0 <= BRAM_PORTB_dout;
      if (pipe_vld[RD_LAT] &&  pipe_tag[RD_LAT]) rd_data_1 <= BRAM_PORTB_dout;
    end
  end

`ifdef PORTB_ARB_STATS_EN
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      stat_beats_0 <= 32'd0;
      stat_beats_1 <= 32'd0;
      stat_stall   <= 32'd0;
    end else begin
      if (beat_0 && stat_beats_0 != 32'hFFFF_FFFF) stat_beats_0 <= stat_beats_0 + 32'd1;
      if (beat_1 && stat_beats_1 != 32'hFFFF_FFFF) stat_beats_1 <= stat_beats_1 + 32'd1;
      if (((req_0 && !gnt_0) || (req_1 && !gnt_1)) && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bram_portb_arbiter
//   Directed self-checking bench with a write-first BRAM model on port B.
//   Revision: 1.0
// ============================================================================
module tb_bram_portb_arbiter;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_0, req_1, lock_0, lock_1, we_0, we_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic              gnt_0, gnt_1, rd_valid_0, rd_valid_1;
  logic [DATA_W-1:0] rd_data_0, rd_data_1;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  logic              bram_rst;
`ifdef PORTB_ARB_STATS_EN
  logic [31:0]       stat_beats_0, stat_beats_1, stat_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] pre [3] = '{32'h2222_cafe, 32'h3333_babe, 32'h4444_feed};

  always #5 clk = ~clk;

  bram_portb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req_0(req_0), .req_1(req_1), .lock_0(lock_0), .lock_1(lock_1),
    .we_0(we_0), .we_1(we_1), .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
    .BRAM_PORTB_en(bram_en), .BRAM_PORTB_we(bram_we), .BRAM_PORTB_addr(bram_addr),
    .BRAM_PORTB_din(bram_din), .BRAM_PORTB_dout(bram_dout), .BRAM_PORTB_rst(bram_rst)
`ifdef PORTB_ARB_STATS_EN
    , .stat_beats_0(stat_beats_0), .stat_beats_1(stat_beats_1), .stat_stall(stat_stall)
`endif
  );

  // Write-first BRAM, one cycle from captured enable to dout.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we == 4'hF) begin
        mem[bram_addr] <= bram_din;
        bram_dout      <= bram_din;
      end else begin
        bram_dout      <= mem[bram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en",    32'(bram_en), 32'd0);
    check("rst_we",    32'(bram_we), 32'd0);
    check("rst_addr",  32'(bram_addr), 32'd0);
    check("rst_din",   bram_din, 32'd0);
    check("rst_gnt",   32'({gnt_0, gnt_1}), 32'd0);
    check("rst_rdv",   32'({rd_valid_0, rd_valid_1}), 32'd0);
    check("rst_pin",   32'(bram_rst), 32'd1);
    next();

    // Both requesting, unlocked: strict alternation starting at req 0.
    rst = 1'b0;
    req_0 = 1; req_1 = 1; we_0 = 1; we_1 = 1;
    addr_0 = 10'h040; wdata_0 = 32'hA0A0_0000;
    addr_1 = 10'h041; wdata_1 = 32'hB1B1_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_gnt0", 32'(gnt_0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t1_gnt1", 32'(gnt_1), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("t1_en",   32'(bram_en), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check("t1_addr", 32'(bram_addr), (i % 2 == 1) ? 32'h40 : 32'h41);
        check("t1_we",   32'(bram_we), 32'hF);
      end
      next();
    end
    req_0 = 0; req_1 = 0;
    @(negedge clk);
    check("t1_en_last", 32'(bram_en), 32'd1);
    check("t1_din_last", bram_din, 32'hB1B1_0000);
    next();
    @(negedge clk);
    check("t1_en_off", 32'(bram_en), 32'd0);
    next();

    // Write then read the same word; return counted in cycles after the read is presented.
    req_0 = 1; we_0 = 1; addr_0 = 10'h005; wdata_0 = 32'h1111_fade;
    @(negedge clk);
    check("t2_wr_gnt", 32'(gnt_0), 32'd1);
    next();
    we_0 = 0;
    @(negedge clk);
    check("t2_rd_gnt", 32'(gnt_0), 32'd1);
    next();
    req_0 = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t2_rdv0", 32'(rd_valid_0), (c == RD_LAT + 2) ? 32'd1 : 32'd0);
      check("t2_rdv1", 32'(rd_valid_1), 32'd0);
      if (c == RD_LAT + 2) check("t2_rdata0", rd_data_0, 32'h1111_fade);
      next();
    end

    // Preload three words through req 1.
    req_1 = 1; we_1 = 1; lock_1 = 0;
    for (int c = 0; c < 3; c++) begin
      addr_1 = 10'(10'h010 + c); wdata_1 = pre[c];
      @(negedge clk);
      check("pre_gnt1", 32'(gnt_1), 32'd1);
      next();
    end
    req_1 = 0;
    @(negedge clk);
    next();

    // Locked burst of 12 against a persistent competitor: rotation after beat 8.
    req_0 = 1; lock_0 = 1; we_0 = 1; wdata_0 = 32'h0;
    req_1 = 1; lock_1 = 0; we_1 = 1; addr_1 = 10'h200; wdata_1 = 32'h0;
    for (int c = 0; c < 13; c++) begin
      addr_0 = 10'(10'h100 + c);
      @(negedge clk);
      check("t3_gnt0", 32'(gnt_0), (c != 8) ? 32'd1 : 32'd0);
      check("t3_gnt1", 32'(gnt_1), (c == 8) ? 32'd1 : 32'd0);
      next();
    end
    req_0 = 0; lock_0 = 0;
    @(negedge clk);
    check("t3_hand_gnt0", 32'(gnt_0), 32'd0);
    check("t3_hand_gnt1", 32'(gnt_1), 32'd1);
    next();
    req_1 = 0;
    @(negedge clk);
    next();

    // Locked burst of 12 alone: no gap at the beat limit.
    req_0 = 1; lock_0 = 1; we_0 = 1;
    for (int c = 0; c < 12; c++) begin
      addr_0 = 10'(10'h180 + c);
      @(negedge clk);
      check("t4_gnt0", 32'(gnt_0), 32'd1);
      check("t4_gnt1", 32'(gnt_1), 32'd0);
      check("t4_en",   32'(bram_en), (c > 0) ? 32'd1 : 32'd0);
      next();
    end
    req_0 = 0; lock_0 = 0;
    @(negedge clk);
    next();
    @(negedge clk);
    next();

    // Back-to-back reads by req 1 return in issue order.
    req_1 = 1; we_1 = 0; lock_1 = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) addr_1 = 10'(10'h010 + c);
      if (c == 3) req_1 = 0;
      @(negedge clk);
      if (c < 3) check("t5_gnt1", 32'(gnt_1), 32'd1);
      check("t5_rdv1", 32'(rd_valid_1),
            (c >= RD_LAT + 2 && c < RD_LAT + 5) ? 32'd1 : 32'd0);
      check("t5_rdv0", 32'(rd_valid_0), 32'd0);
      if (c >= RD_LAT + 2 && c < RD_LAT + 5)
        check("t5_rdata1", rd_data_1, pre[c - (RD_LAT + 2)]);
      next();
    end

    // Reset right after a locked read: flushed return, released ownership.
    req_0 = 1; lock_0 = 1; we_0 = 0; addr_0 = 10'h005;
    @(negedge clk);
    check("t6_gnt0", 32'(gnt_0), 32'd1);
    next();
    req_0 = 0; lock_0 = 0; rst = 1;
    @(negedge clk);
    check("t6_en_issued", 32'(bram_en), 32'd1);
    next();
    rst = 0;
    req_0 = 1; req_1 = 1; we_0 = 1; we_1 = 1; addr_0 = 10'h300; addr_1 = 10'h301;
    @(negedge clk);
    check("t6_en",    32'(bram_en), 32'd0);
    check("t6_we",    32'(bram_we), 32'd0);
    check("t6_addr",  32'(bram_addr), 32'd0);
    check("t6_din",   bram_din, 32'd0);
    check("t6_rdv",   32'({rd_valid_0, rd_valid_1}), 32'd0);
    check("t6_rdata0", rd_data_0, 32'd0);
    check("t6_rdata1", rd_data_1, 32'd0);
    check("t6_gnt0",  32'(gnt_0), 32'd1);
    check("t6_gnt1",  32'(gnt_1), 32'd0);
    next();
    req_0 = 0; req_1 = 0;
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      check("t6_rdv0_flushed", 32'(rd_valid_0), 32'd0);
      check("t6_rdv1_flushed", 32'(rd_valid_1), 32'd0);
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
